id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage. It sits directly downstream of the control decoder and captures the decoder's control bundle together with the register operands, immediate and PCs into the EX-stage register. It also detects load-use hazards, inserts bubbles, honours branch/jump flushes and memory-stall holds, and keeps saturating hazard-event counters for debug.

Parameters:
XLEN, 32, datapath width of operands, immediate and PCs
CNT_W, 16, width of each saturating hazard counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
RegWriteD  in  1  decoder register-write enable
ResultSrcD  in  2  writeback source (00 ALU, 01 memory, 10 PC+4)
MemWriteD  in  1  store enable
jumpD  in  1  jump (JAL/JALR)
jumpR  in  1  register-relative jump (JALR)
BranchD  in  1  conditional branch
ALUControlD  in  4  ALU operation
ALUSrcD  in  1  ALU operand B select (1 = immediate)
FUN3D  in  3  funct3 pass-through
ALUTypeD  in  2  instruction class
validD  in  1  ID holds a real instruction
RD1D, RD2D  in  XLEN  register-file read data
ImmExtD, PCD, PCPlus4D  in  XLEN  extended immediate, PC, PC+4
Rs1D, Rs2D, RdD  in  5  register indices
flushE  in  1  branch/jump taken in EX; kill the instruction entering E
memStall  in  1  data memory busy; freeze F, D and E
*E outputs  out  same widths  registered copies of every D input above (RegWriteE ... RdE, jumpRE, FUN3E, ALUTypeE)
validE  out  1  E holds a real instruction
stallF, stallD  out  1  combinational; hold PC and IF/ID register
lwStallCnt, flushCnt, memStallCnt  out  CNT_W  saturating event counters

Behaviour:
- Reset (async, rst=1): every registered output, validE and all counters go to 0 immediately. stallF and stallD read 0 while in reset.
- Operand-use decode, on D inputs:
  - useRs1 = validD & ~(jumpD & ~jumpR).
  - useRs2 = validD & (~ALUSrcD | MemWriteD | BranchD).
- lwStall = validE & RegWriteE & (ResultSrcE==01) & (RdE!=0) & ((useRs1 & Rs1D==RdE) | (useRs2 & Rs2D==RdE)).
- stallF = stallD = lwStall | memStall. This path is combinational with no added latency.
- E-register update on each rising edge, highest priority first:
  1. flushE=1 -> bubble (all control outputs 0, validE=0; data outputs don't-care but driven 0). flushE overrides memStall.
  2. memStall=1 -> hold all E contents unchanged.
  3. lwStall=1 -> bubble. The D instruction stays in ID because stallD=1, and it enters E on the next free cycle.
  4. Otherwise -> load every D input into E; validE=validD.
- A bubble clears RegWriteE, MemWriteE, jumpE, BranchE and validE, so it has no architectural effect.
- Latency: one cycle from D to E. Throughput is one instruction per cycle when no hazard is present.
- Counters increment by 1 on each rising edge where their condition holds, and stick at 2^CNT_W-1:
  - lwStallCnt: lwStall & ~memStall & ~flushE.
  - flushCnt: flushE.
  - memStallCnt: memStall.
- Simultaneous events:
  - flushE & lwStall: flush wins, and lwStall is not counted. The load that caused lwStall is still in E this cycle and leaves next cycle.
  - memStall & lwStall: hold wins. lwStall re-evaluates after memStall drops.
- Rd=x0 never causes a stall.
- A bubble in E (validE=0) never causes a stall.
- Reset asserted mid-stall clears everything. After rst drops, the first edge loads D normally.

Test Plan:
- Pass-through: ADD x3,x1,x2 (RegWriteD=1, ALUControlD=0010, RD1D=5, RD2D=7, RdD=3, validD=1) -> next edge RegWriteE=1, ALUControlE=0010, RD1E=5, RD2E=7, RdE=3, validE=1, stallF=0.
- Load-use: LW x5 in E (ResultSrcE=01, RdE=5), then ADD x6,x5,x1 in D -> stallF=stallD=1 for exactly one cycle. Next edge validE=0 (bubble). Following edge ADD appears in E. lwStallCnt=1.
- Load to x0 / rs2 unused: LW x0 in E with Rs1D=0 -> no stall. LW x5 in E with ADDI (ALUSrcD=1) using Rs2D=5 -> no stall.
- Flush: flushE=1 while a valid SW is in D -> next edge MemWriteE=0, validE=0, flushCnt=1. Repeat with flushE and memStall both high -> bubble, not hold.
- memStall held 3 cycles with ADD in E -> E outputs unchanged all 3 cycles, stallF=1, memStallCnt=3. The next D instruction loads on the first edge after release.
- Reset mid-operation: assert rst asynchronously between edges during a lwStall -> validE and counters 0 immediately, stallF=0. Force counters near saturation (CNT_W=2, 5 flushes) -> flushCnt=3.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX bundle: decoder-side D fields and EX-register E fields
//
// master: the decode side, drives the *D fields and observes the *E fields
// slave : the ID/EX stage, samples the *D fields and drives the *E fields
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  // Decode-side bundle
  logic            RegWriteD;
  logic [1:0]      ResultSrcD;
  logic            MemWriteD;
  logic            jumpD;
  logic            jumpR;
  logic            BranchD;
  logic [3:0]      ALUControlD;
  logic            ALUSrcD;
  logic [2:0]      FUN3D;
  logic [1:0]      ALUTypeD;
  logic            validD;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [XLEN-1:0] ImmExtD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic [4:0]      RdD;

  // Execute-stage register copies
  logic            RegWriteE;
  logic [1:0]      ResultSrcE;
  logic            MemWriteE;
  logic            jumpE;
  logic            jumpRE;
  logic            BranchE;
  logic [3:0]      ALUControlE;
  logic            ALUSrcE;
  logic [2:0]      FUN3E;
  logic [1:0]      ALUTypeE;
  logic            validE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;

  modport master (
    output RegWriteD, ResultSrcD, MemWriteD, jumpD, jumpR, BranchD, ALUControlD,
           ALUSrcD, FUN3D, ALUTypeD, validD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
           Rs1D, Rs2D, RdD,
    input  RegWriteE, ResultSrcE, MemWriteE, jumpE, jumpRE, BranchE, ALUControlE,
           ALUSrcE, FUN3E, ALUTypeE, validE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE
  );

  modport slave (
    input  RegWriteD, ResultSrcD, MemWriteD, jumpD, jumpR, BranchD, ALUControlD,
           ALUSrcD, FUN3D, ALUTypeD, validD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
           Rs1D, Rs2D, RdD,
    output RegWriteE, ResultSrcE, MemWriteE, jumpE, jumpRE, BranchE, ALUControlE,
           ALUSrcE, FUN3E, ALUTypeE, validE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   bus (slave)       decoder bundle in (*D), EX-stage register out (*E)
//   flushE            kill the instruction entering EX (bubble), beats memStall
//   memStall          data memory busy: hold EX and stall F/D
//   stallF, stallD    combinational stall for PC and IF/ID register
//   lwStallCnt, flushCnt, memStallCnt  saturating debug event counters
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_if.slave     bus,
  input  logic             flushE,
  input  logic             memStall,
  output logic             stallF,
  output logic             stallD,
  output logic [CNT_W-1:0] lwStallCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic [CNT_W-1:0] memStallCnt
);

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            jump_r;
    logic            branch;
    logic [3:0]      alu_control;
    logic            alu_src;
    logic [2:0]      fun3;
    logic [1:0]      alu_type;
    logic            valid;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } stage_t;

  stage_t d_in;
  stage_t e_q;
  logic   use_rs1;
  logic   use_rs2;
  logic   lw_stall;

  always_comb begin
    d_in             = '0;
    d_in.reg_write   = bus.RegWriteD;
    d_in.result_src  = bus.ResultSrcD;
    d_in.mem_write   = bus.MemWriteD;
    d_in.jump        = bus.jumpD;
    d_in.jump_r      = bus.jumpR;
    d_in.branch      = bus.BranchD;
    d_in.alu_control = bus.ALUControlD;
    d_in.alu_src     = bus.ALUSrcD;
    d_in.fun3        = bus.FUN3D;
    d_in.alu_type    = bus.ALUTypeD;
    d_in.valid       = bus.validD;
    d_in.rd1         = bus.RD1D;
    d_in.rd2         = bus.RD2D;
    d_in.imm_ext     = bus.ImmExtD;
    d_in.pc          = bus.PCD;
    d_in.pc_plus4    = bus.PCPlus4D;
    d_in.rs1         = bus.Rs1D;
    d_in.rs2         = bus.Rs2D;
    d_in.rd          = bus.RdD;
  end

  // JAL has no rs1 operand; rs2 is read by R-type ALU ops, stores and branches.
  assign use_rs1 = bus.validD & ~(bus.jumpD & ~bus.jumpR);
  assign use_rs2 = bus.validD & (~bus.ALUSrcD | bus.MemWriteD | bus.BranchD);

  // A valid load in EX whose destination (not x0) is read by the ID instruction.
  assign lw_stall = e_q.valid & e_q.reg_write & (e_q.result_src == 2'b01) &
                    (e_q.rd != 5'd0) &
                    ((use_rs1 & (bus.Rs1D == e_q.rd)) | (use_rs2 & (bus.Rs2D == e_q.rd)));

  // Gated by rst so the front end is never told to stall while the pipe is held in reset.
  assign stallF = ~rst & (lw_stall | memStall);
  assign stallD = stallF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= '0;
    end else if (flushE) begin
      e_q <= '0;
    end else if (memStall) begin
      e_q <= e_q;
    end else if (lw_stall) begin
      e_q <= '0;
    end else begin
      e_q <= d_in;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lwStallCnt  <= '0;
      flushCnt    <= '0;
      memStallCnt <= '0;
    end else begin
      // Only a load-use stall that actually produces the bubble is counted.
      if (lw_stall && !memStall && !flushE) lwStallCnt <= sat_inc(lwStallCnt);
      if (flushE) flushCnt <= sat_inc(flushCnt);
      if (memStall) memStallCnt <= sat_inc(memStallCnt);
    end
  end

  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.ResultSrcE  = e_q.result_src;
  assign bus.MemWriteE   = e_q.mem_write;
  assign bus.jumpE       = e_q.jump;
  assign bus.jumpRE      = e_q.jump_r;
  assign bus.BranchE     = e_q.branch;
  assign bus.ALUControlE = e_q.alu_control;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.FUN3E       = e_q.fun3;
  assign bus.ALUTypeE    = e_q.alu_type;
  assign bus.validE      = e_q.valid;
  assign bus.RD1E        = e_q.rd1;
  assign bus.RD2E        = e_q.rd2;
  assign bus.ImmExtE     = e_q.imm_ext;
  assign bus.PCE         = e_q.pc;
  assign bus.PCPlus4E    = e_q.pc_plus4;
  assign bus.Rs1E        = e_q.rs1;
  assign bus.Rs2E        = e_q.rs2;
  assign bus.RdE         = e_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed checks of id_ex_stage against a reference model
module tb_id_ex_stage;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic        j;
    logic        jr;
    logic        br;
    logic [3:0]  alu;
    logic        asrc;
    logic [2:0]  f3;
    logic [1:0]  at;
    logic        v;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst;
  logic flushE;
  logic memStall;
  logic stallF, stallD, stallF2, stallD2;
  logic [15:0] lwStallCnt, flushCnt, memStallCnt;
  logic [1:0]  lw2, fl2, ms2;

  int total = 0;
  int bad   = 0;

  ins_t cur;
  ins_t exp_e;
  int   n_lw, n_fl, n_ms;
  logic held;

  id_ex_stage_if #(.XLEN(32)) bus ();
  id_ex_stage_if #(.XLEN(32)) bus2 ();

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flushE(flushE), .memStall(memStall),
    .stallF(stallF), .stallD(stallD),
    .lwStallCnt(lwStallCnt), .flushCnt(flushCnt), .memStallCnt(memStallCnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .flushE(flushE), .memStall(memStall),
    .stallF(stallF2), .stallD(stallD2),
    .lwStallCnt(lw2), .flushCnt(fl2), .memStallCnt(ms2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic logic [255:0] sat(input int n, input int w);
    int m;
    m = (1 << w) - 1;
    return (n > m) ? 256'(m) : 256'(n);
  endfunction

  // Load-use rule: a valid load in E writing a nonzero register read by the D instruction.
  function automatic logic model_lw(input ins_t e, input ins_t d);
    logic u1, u2;
    u1 = d.v && !(d.j && !d.jr);
    u2 = d.v && (!d.asrc || d.mw || d.br);
    return e.v && e.rw && (e.rs == 2'b01) && (e.rd != 5'd0) &&
           ((u1 && d.rs1 == e.rd) || (u2 && d.rs2 == e.rd));
  endfunction

  function automatic ins_t read_e();
    ins_t x;
    x.rw = bus.RegWriteE;   x.rs = bus.ResultSrcE;  x.mw = bus.MemWriteE;
    x.j = bus.jumpE;        x.jr = bus.jumpRE;      x.br = bus.BranchE;
    x.alu = bus.ALUControlE; x.asrc = bus.ALUSrcE;  x.f3 = bus.FUN3E;
    x.at = bus.ALUTypeE;    x.v = bus.validE;       x.rd1 = bus.RD1E;
    x.rd2 = bus.RD2E;       x.imm = bus.ImmExtE;    x.pc = bus.PCE;
    x.pc4 = bus.PCPlus4E;   x.rs1 = bus.Rs1E;       x.rs2 = bus.Rs2E;
    x.rd = bus.RdE;
    return x;
  endfunction

  task automatic apply(input ins_t x);
    bus.RegWriteD = x.rw;    bus.ResultSrcD = x.rs;  bus.MemWriteD = x.mw;
    bus.jumpD = x.j;         bus.jumpR = x.jr;       bus.BranchD = x.br;
    bus.ALUControlD = x.alu; bus.ALUSrcD = x.asrc;   bus.FUN3D = x.f3;
    bus.ALUTypeD = x.at;     bus.validD = x.v;       bus.RD1D = x.rd1;
    bus.RD2D = x.rd2;        bus.ImmExtD = x.imm;    bus.PCD = x.pc;
    bus.PCPlus4D = x.pc4;    bus.Rs1D = x.rs1;       bus.Rs2D = x.rs2;
    bus.RdD = x.rd;
    bus2.RegWriteD = x.rw;    bus2.ResultSrcD = x.rs;  bus2.MemWriteD = x.mw;
    bus2.jumpD = x.j;         bus2.jumpR = x.jr;       bus2.BranchD = x.br;
    bus2.ALUControlD = x.alu; bus2.ALUSrcD = x.asrc;   bus2.FUN3D = x.f3;
    bus2.ALUTypeD = x.at;     bus2.validD = x.v;       bus2.RD1D = x.rd1;
    bus2.RD2D = x.rd2;        bus2.ImmExtD = x.imm;    bus2.PCD = x.pc;
    bus2.PCPlus4D = x.pc4;    bus2.Rs1D = x.rs1;       bus2.Rs2D = x.rs2;
    bus2.RdD = x.rd;
  endtask

  function automatic ins_t rand_ins();
    ins_t x;
    x.rw = 1'($urandom_range(0, 1));
    x.rs = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
    x.mw = 1'($urandom_range(0, 1));
    x.j = ($urandom_range(0, 4) == 0);
    x.jr = 1'($urandom_range(0, 1));
    x.br = ($urandom_range(0, 3) == 0);
    x.alu = 4'($urandom_range(0, 15));
    x.asrc = 1'($urandom_range(0, 1));
    x.f3 = 3'($urandom_range(0, 7));
    x.at = 2'($urandom_range(0, 3));
    x.v = ($urandom_range(0, 7) != 0);
    x.rd1 = $urandom;
    x.rd2 = $urandom;
    x.imm = $urandom;
    x.pc = $urandom;
    x.pc4 = x.pc + 32'd4;
    x.rs1 = 5'($urandom_range(0, 3));
    x.rs2 = 5'($urandom_range(0, 3));
    x.rd = 5'($urandom_range(0, 3));
    return x;
  endfunction

  task automatic model_reset();
    exp_e = '0;
    n_lw = 0;
    n_fl = 0;
    n_ms = 0;
    held = 1'b0;
  endtask

  // One clock edge: advance the reference model from the inputs present at the edge.
  task automatic tick();
    logic st;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      st = model_lw(exp_e, cur);
      held = st || memStall;
      if (memStall) n_ms++;
      if (flushE) n_fl++;
      if (st && !memStall && !flushE) n_lw++;
      if (flushE) exp_e = '0;
      else if (memStall) exp_e = exp_e;
      else if (st) exp_e = '0;
      else exp_e = cur;
    end
    #1;
  endtask

  always @(negedge clk) begin
    logic es;
    es = !rst && (model_lw(exp_e, cur) || memStall);
    chk("e_regs", 256'(read_e()), 256'(exp_e));
    chk("stallF", 256'(stallF), 256'(es));
    chk("stallD", 256'(stallD), 256'(es));
    chk("lwStallCnt", 256'(lwStallCnt), sat(n_lw, 16));
    chk("flushCnt", 256'(flushCnt), sat(n_fl, 16));
    chk("memStallCnt", 256'(memStallCnt), sat(n_ms, 16));
    chk("lwStallCnt_w2", 256'(lw2), sat(n_lw, 2));
    chk("flushCnt_w2", 256'(fl2), sat(n_fl, 2));
    chk("memStallCnt_w2", 256'(ms2), sat(n_ms, 2));
    chk("stallF_w2", 256'(stallF2), 256'(es));
  end

  initial begin
    ins_t add_i, lw_i, use_i, sw_i, x_i;
    int ms_before;

    rst = 1'b1;
    flushE = 1'b0;
    memStall = 1'b1;
    cur = '0;
    apply(cur);
    model_reset();
    #2;
    chk("rst_validE", 256'(bus.validE), 256'(0));
    chk("rst_stallF_with_memStall", 256'(stallF), 256'(0));
    chk("rst_lwCnt", 256'(lwStallCnt), 256'(0));
    tick();
    tick();
    rst = 1'b0;
    memStall = 1'b0;

    // Pass-through: ADD x3,x1,x2
    add_i = '0;
    add_i.v = 1'b1; add_i.rw = 1'b1; add_i.alu = 4'b0010;
    add_i.rd1 = 32'd5; add_i.rd2 = 32'd7; add_i.rs1 = 5'd1; add_i.rs2 = 5'd2; add_i.rd = 5'd3;
    cur = add_i; apply(cur);
    tick();
    chk("pt_RegWriteE", 256'(bus.RegWriteE), 256'(1));
    chk("pt_ALUControlE", 256'(bus.ALUControlE), 256'(4'b0010));
    chk("pt_RD1E", 256'(bus.RD1E), 256'(5));
    chk("pt_RD2E", 256'(bus.RD2E), 256'(7));
    chk("pt_RdE", 256'(bus.RdE), 256'(3));
    chk("pt_validE", 256'(bus.validE), 256'(1));
    chk("pt_stallF", 256'(stallF), 256'(0));

    // Load-use: LW x5 then ADD x6,x5,x1
    lw_i = '0;
    lw_i.v = 1'b1; lw_i.rw = 1'b1; lw_i.rs = 2'b01; lw_i.asrc = 1'b1;
    lw_i.rs1 = 5'd1; lw_i.rd = 5'd5;
    cur = lw_i; apply(cur);
    tick();
    use_i = '0;
    use_i.v = 1'b1; use_i.rw = 1'b1; use_i.rs1 = 5'd5; use_i.rs2 = 5'd1; use_i.rd = 5'd6;
    cur = use_i; apply(cur);
    #1;
    chk("lu_stallF", 256'(stallF), 256'(1));
    chk("lu_stallD", 256'(stallD), 256'(1));
    tick();
    chk("lu_bubble_validE", 256'(bus.validE), 256'(0));
    chk("lu_after_stallF", 256'(stallF), 256'(0));
    tick();
    chk("lu_add_RdE", 256'(bus.RdE), 256'(6));
    chk("lu_add_validE", 256'(bus.validE), 256'(1));
    chk("lu_lwStallCnt", 256'(lwStallCnt), 256'(1));

    // Load to x0, and rs2 not read by an ADDI
    lw_i.rd = 5'd0;
    cur = lw_i; apply(cur);
    tick();
    x_i = '0; x_i.v = 1'b1; x_i.rw = 1'b1; x_i.asrc = 1'b1; x_i.rs1 = 5'd0; x_i.rd = 5'd7;
    cur = x_i; apply(cur);
    #1;
    chk("x0_no_stall", 256'(stallF), 256'(0));
    lw_i.rd = 5'd5;
    cur = lw_i; apply(cur);
    tick();
    x_i.rs1 = 5'd1; x_i.rs2 = 5'd5;
    cur = x_i; apply(cur);
    #1;
    chk("addi_rs2_no_stall", 256'(stallF), 256'(0));
    tick();

    // Flush with a valid SW in D, then flush together with memStall
    sw_i = '0; sw_i.v = 1'b1; sw_i.mw = 1'b1; sw_i.asrc = 1'b1; sw_i.rs1 = 5'd2; sw_i.rs2 = 5'd3;
    cur = sw_i; apply(cur);
    flushE = 1'b1;
    tick();
    chk("fl_MemWriteE", 256'(bus.MemWriteE), 256'(0));
    chk("fl_validE", 256'(bus.validE), 256'(0));
    chk("fl_flushCnt", 256'(flushCnt), 256'(1));
    flushE = 1'b0;
    cur = add_i; apply(cur);
    tick();
    cur = sw_i; apply(cur);
    flushE = 1'b1;
    memStall = 1'b1;
    tick();
    chk("flms_validE", 256'(bus.validE), 256'(0));
    chk("flms_flushCnt", 256'(flushCnt), 256'(2));
    chk("flms_memStallCnt", 256'(memStallCnt), 256'(1));
    flushE = 1'b0;
    memStall = 1'b0;

    // memStall held for 3 cycles with ADD in E
    cur = add_i; apply(cur);
    tick();
    x_i = add_i; x_i.rd = 5'd9; x_i.rd1 = 32'd11;
    cur = x_i; apply(cur);
    memStall = 1'b1;
    ms_before = int'(memStallCnt);
    #1;
    chk("ms_stallF", 256'(stallF), 256'(1));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ms_hold_RdE", 256'(bus.RdE), 256'(3));
      chk("ms_hold_validE", 256'(bus.validE), 256'(1));
    end
    chk("ms_memStallCnt", 256'(memStallCnt), 256'(ms_before + 3));
    memStall = 1'b0;
    tick();
    chk("ms_release_RdE", 256'(bus.RdE), 256'(9));

    // Reset asserted between edges during a load-use stall
    cur = lw_i; apply(cur);
    tick();
    cur = use_i; apply(cur);
    #1;
    chk("rs_pre_stallF", 256'(stallF), 256'(1));
    rst = 1'b1;
    model_reset();
    #1;
    chk("rs_validE", 256'(bus.validE), 256'(0));
    chk("rs_lwStallCnt", 256'(lwStallCnt), 256'(0));
    chk("rs_flushCnt", 256'(flushCnt), 256'(0));
    chk("rs_memStallCnt", 256'(memStallCnt), 256'(0));
    chk("rs_stallF", 256'(stallF), 256'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("rs_first_load_RdE", 256'(bus.RdE), 256'(6));
    chk("rs_first_load_validE", 256'(bus.validE), 256'(1));

    // Five flushes: 16-bit counter reads 5, 2-bit counter saturates at 3
    flushE = 1'b1;
    repeat (5) tick();
    flushE = 1'b0;
    chk("sat_flushCnt16", 256'(flushCnt), 256'(5));
    chk("sat_flushCnt2", 256'(fl2), 256'(3));

    // Randomized traffic; the decoder holds D whenever the stage stalled it
    held = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!held) cur = rand_ins();
      apply(cur);
      flushE = ($urandom_range(0, 9) == 0);
      memStall = ($urandom_range(0, 6) == 0);
      tick();
    end
    flushE = 1'b0;
    memStall = 1'b0;
    tick();
    chk("end_flushCnt2_saturated", 256'(fl2), 256'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
